lsq_moment_acc: RTL
===================

Name: lsq_moment_acc

Overview:
- Streaming accumulator for least-squares polynomial regression in the option-pricing datapath.
- Over one batch of N (x, y) samples it produces the Gram-matrix moments Σx^k for k=0..2·DEG and the projection moments Σx^k·y for k=0..DEG.
- Sits between the path/payoff sample generator and the matrix-inverse/solve block.
- Replaces fixed-degree, fixed-N accumulators: degree and width are parametrised, and it adds valid/ready handshakes on both sides, abort, and output hold.

Parameters:
- XW, 16: x sample width, unsigned.
- YW, 16: y sample width, unsigned. Must satisfy YW ≤ DEG·XW.
- DEG, 2: polynomial degree, 1..4.
- N, 256: samples per batch, ≥1.
- CW, clog2(N+1): sample counter width (derived).
- ACC_W, 2·DEG·XW+CW: width of every accumulator (derived). Overflow-free by construction.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle batch start; honoured only in IDLE
- clear  in  1  synchronous abort; returns to IDLE from any state
- in_valid  in  1  sample valid
- in_ready  out  1  sample accept
- x_i  in  XW  regressor sample
- y_i  in  YW  target sample
- out_valid  out  1  moments valid
- out_ready  in  1  consumer accepts moments
- sxx  out  (2·DEG+1)·ACC_W  Σx^k; slice k = bits [k·ACC_W +: ACC_W]
- sxy  out  (DEG+1)·ACC_W  Σx^k·y; slice k as above
- busy  out  1  high in ACC or DRAIN

Behaviour:
- Reset, asynchronous: state=IDLE, count=0, all accumulators 0, in_ready=0, out_valid=0, busy=0.
- States: IDLE, ACC, DRAIN (pipelined build only), DONE.
- IDLE:
  - On start: clear all accumulators and count in the same edge, go to ACC.
  - Outputs sxx/sxy keep their last values and are not valid.
- ACC:
  - in_ready=1.
  - A sample is accepted when in_valid&in_ready. It adds x^k to sxx[k], x^k·y to sxy[k], and 1 to sxx[0]; count increments.
  - No accept in a cycle: accumulators hold. Gaps in in_valid are legal.
  - On the accept that makes count==N:
    - in_ready drops the next cycle.
    - Go to DONE, or to DRAIN when the pipeline macro is on.
  - Exactly N samples are accepted per batch, never N+1.
- DONE:
  - out_valid=1; sxx/sxy stable.
  - Held until out_valid&out_ready, then IDLE the next cycle with out_valid=0.
  - Accumulators are not cleared on exit; they clear on the next start.
- start outside IDLE is ignored.
- clear has priority over start and over sample accept: next state IDLE, count=0, accumulators 0, out_valid=0.
- Simultaneous start and clear in IDLE: clear wins and the FSM stays in IDLE.
- Reset mid-batch: all state returns to reset values; the partial batch is discarded.
- Arithmetic:
  - Unsigned throughout.
  - x powers come from a multiply chain: x^(k+1) = x^k·x, each power at its full width k·XW.
  - All products are zero-extended to ACC_W before addition. No truncation or saturation is needed.
- Latency, base build: last sample accepted at edge t -> out_valid=1 from t+1.

Optional Feature:
- Macro: LSQ_PWR_PIPE_EN.
- Defined:
  - One register stage after the power chain (powers, x^k·y, valid).
  - FSM passes through DRAIN for one cycle after the N-th accept, so out_valid rises at t+2.
  - clear also flushes the pipeline valid.
- Undefined:
  - Purely combinational power chain, no DRAIN state.
  - Latency t+1.

Decomposition:
- Package lsq_pkg:
  - state enum (IDLE, ACC, DRAIN, DONE)
  - function computing ACC_W from XW, DEG, N
  - DEG range limits
- Sub-module lsq_pow_chain (params XW, DEG): x_i -> x^1..x^(2·DEG).
  - Combinational, or one registered stage under LSQ_PWR_PIPE_EN.
  - The top level handles the y products, accumulation and FSM.

Test Plan:
- Basic moments (N=4, DEG=2): start; x=1,2,3,4 with y=2,4,6,8, back-to-back -> sxx={4,10,30,100,354}, sxy={20,60,200}, out_valid at t+1 (t+2 with LSQ_PWR_PIPE_EN).
- Input gaps and extra sample: same data with in_valid low every other cycle, plus a 5th sample offered after the 4th -> identical sums; 5th sample not accepted (in_ready=0).
- Output backpressure: out_ready held low for 10 cycles -> out_valid and sums stable throughout. Pulsing out_ready -> IDLE next cycle. A start sent during DONE is ignored.
- Abort: clear after 2 of 4 samples -> IDLE, sums 0. A new start with x=2,2,2,2 and y=1,1,1,1 -> sxx={4,8,16,32,64}, sxy={4,8,16}.
- Overflow bound (N=256, XW=16, DEG=2): x=65535 and y=65535 for all samples -> sxx[4] = 256·65535^4 exactly, sxy[2] = 256·65535^3 exactly, no wrap.
- Async reset after 3 of 4 samples -> all outputs 0 and state IDLE. A following start with a full batch gives the correct sums.

Source files
------------

// File: rtl/lsq_pkg.sv
// Shared types and sizing helpers for the least-squares moment accumulator.
package lsq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAcc,
    StDrain,
    StDone
  } lsq_state_e;

  localparam int unsigned DegMin = 1;
  localparam int unsigned DegMax = 4;

  // Wide enough for N sums of x^(2*DEG) without wrap.
  function automatic int unsigned lsq_acc_w(input int unsigned xw, input int unsigned deg,
                                            input int unsigned n);
    return 2 * deg * xw + $clog2(n + 1);
  endfunction

endpackage

// File: rtl/lsq_pow_chain.sv
// Power chain x -> x^1..x^(2*DEG); one register stage when LSQ_PWR_PIPE_EN is defined.
module lsq_pow_chain #(
  parameter int unsigned XW  = 16,
  parameter int unsigned DEG = 2,
  parameter int unsigned YW  = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           in_vld,
  input  logic [XW-1:0]                  x_i,
  input  logic [YW-1:0]                  y_i,
  output logic                           out_vld,
  output logic [2*DEG:1][2*DEG*XW-1:0]   pw,
  output logic [YW-1:0]                  y_o
);

  localparam int unsigned PW = 2 * DEG * XW;

  logic [2*DEG:1][PW-1:0] pw_c;

  // Each stage truncates to PW bits; x^k needs only k*XW of them.
  assign pw_c[1] = PW'(x_i);
  for (genvar k = 2; k <= 2 * DEG; k++) begin : g_pow
    assign pw_c[k] = pw_c[k-1] * PW'(x_i);
  end

`ifdef LSQ_PWR_PIPE_EN
  logic                   vld_q;
  logic [2*DEG:1][PW-1:0] pw_q;
  logic [YW-1:0]          y_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      pw_q  <= '0;
      y_q   <= '0;
    end else begin
      vld_q <= in_vld & ~flush;
      if (in_vld) begin
        pw_q <= pw_c;
        y_q  <= y_i;
      end
    end
  end

  assign out_vld = vld_q;
  assign pw      = pw_q;
  assign y_o     = y_q;
`else
  logic unused_pipe;
  assign unused_pipe = ^{clk, rst_n, flush};

  assign out_vld = in_vld;
  assign pw      = pw_c;
  assign y_o     = y_i;
`endif

endmodule

// File: rtl/lsq_moment_acc.sv
// Streaming Gram/projection moment accumulator for least-squares regression.
// Optional power-chain pipeline stage: LSQ_PWR_PIPE_EN.
module lsq_moment_acc
  import lsq_pkg::*;
#(
  parameter int unsigned XW    = 16,
  parameter int unsigned YW    = 16,
  parameter int unsigned DEG   = 2,
  parameter int unsigned N     = 256,
  parameter int unsigned CW    = $clog2(N + 1),
  parameter int unsigned ACC_W = lsq_acc_w(XW, DEG, N)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         clear,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [XW-1:0]                x_i,
  input  logic [YW-1:0]                y_i,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [(2*DEG+1)*ACC_W-1:0]   sxx,
  output logic [(DEG+1)*ACC_W-1:0]     sxy,
  output logic                         busy
);

  localparam int unsigned PW = 2 * DEG * XW;

  lsq_state_e state_q, state_d;
  logic [CW-1:0] count_q;
  logic [2*DEG:0][ACC_W-1:0] sxx_q, term_x;
  logic [DEG:0][ACC_W-1:0]   sxy_q, term_y;

  logic                   accept, last, start_batch;
  logic                   acc_vld;
  logic [2*DEG:1][PW-1:0] pw;
  logic [YW-1:0]          pw_y;

  assign accept      = in_valid & in_ready;
  assign last        = (count_q == CW'(N - 1));
  assign start_batch = (state_q == StIdle) & start;

  lsq_pow_chain #(
    .XW  (XW),
    .DEG (DEG),
    .YW  (YW)
  ) u_pow (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (clear),
    .in_vld  (accept),
    .x_i     (x_i),
    .y_i     (y_i),
    .out_vld (acc_vld),
    .pw      (pw),
    .y_o     (pw_y)
  );

  always_comb begin
    term_x    = '0;
    term_y    = '0;
    term_x[0] = ACC_W'(1);
    term_y[0] = ACC_W'(pw_y);
    for (int k = 1; k <= 2 * DEG; k++) term_x[k] = ACC_W'(pw[k]);
    for (int k = 1; k <= DEG; k++) term_y[k] = ACC_W'(pw[k]) * ACC_W'(pw_y);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StAcc;
      StAcc: begin
        if (accept && last) begin
`ifdef LSQ_PWR_PIPE_EN
          state_d = StDrain;
`else
          state_d = StDone;
`endif
        end
      end
      StDrain: state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else if (clear) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      sxx_q   <= '0;
      sxy_q   <= '0;
    end else if (clear || start_batch) begin
      count_q <= '0;
      sxx_q   <= '0;
      sxy_q   <= '0;
    end else begin
      if (accept) count_q <= count_q + CW'(1);
      // In the pipelined build the last sample lands here during the drain cycle.
      if (acc_vld) begin
        for (int k = 0; k <= 2 * DEG; k++) sxx_q[k] <= sxx_q[k] + term_x[k];
        for (int k = 0; k <= DEG; k++) sxy_q[k] <= sxy_q[k] + term_y[k];
      end
    end
  end

  assign in_ready  = (state_q == StAcc);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StAcc) | (state_q == StDrain);
  assign sxx       = sxx_q;
  assign sxy       = sxy_q;

endmodule
